alu_issue_sequencer: RTL

//  Initiator side of the TotalALU function-code interface. Accepts one operation request (func, A, B) on a

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_issue_sequencer_if.sv | 34 +++
 rtl/alu_seq_timer.sv | 38 +++
 rtl/alu_issue_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the TotalALU function-code interface.
//             Holds the function codes, the issue-sequencer state encoding
//             and a helper that tells which request codes are accepted.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Function codes understood by TotalALU (also consumed by ALUControl)
  localparam logic [5:0] c_FUNC_AND  = 6'd36;
  localparam logic [5:0] c_FUNC_OR   = 6'd37;
  localparam logic [5:0] c_FUNC_ADD  = 6'd32;
  localparam logic [5:0] c_FUNC_SUB  = 6'd34;
  localparam logic [5:0] c_FUNC_SLT  = 6'd42;
  localparam logic [5:0] c_FUNC_SRL  = 6'd2;
  localparam logic [5:0] c_FUNC_DIVU = 6'd27;
  localparam logic [5:0] c_FUNC_MFHI = 6'd16;
  localparam logic [5:0] c_FUNC_MFLO = 6'd18;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_DIV_WAIT = 3'd2,
    ST_RD_HI    = 3'd3,
    ST_RD_LO    = 3'd4,
    ST_RESP     = 3'd5
  } seq_state_t;

  // MFHI/MFLO are issued internally only; a front end may not request them.
  function automatic logic is_supported(input logic [5:0] func);
    case (func)
      c_FUNC_AND, c_FUNC_OR, c_FUNC_ADD, c_FUNC_SUB,
      c_FUNC_SLT, c_FUNC_SRL, c_FUNC_DIVU: is_supported = 1'b1;
      default:                             is_supported = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_sequencer_if.sv
// ============================================================================
//  Module   : alu_issue_sequencer_if
//  Purpose  : Request/response handshake bundle between a front end (master)
//             and the ALU issue sequencer (slave).
//  Signals  : req_valid/req_ready/req_func/req_a/req_b  - operation request
//             rsp_valid/rsp_ready/rsp_data/rsp_hi/rsp_err - result response
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_issue_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_func;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_hi;
  logic        rsp_err;

  modport master (
    output req_valid, req_func, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_hi, rsp_err
  );

  modport slave (
    input  req_valid, req_func, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_hi, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq_timer.sv
// ============================================================================
//  Module   : alu_seq_timer
//  Purpose  : Loadable down-counter that times ALU settling / divide latency.
//  Ports    : clk, reset (async active-low)
//             i_load      - load strobe (wins over counting)
//             i_load_val  - value loaded on i_load
//             o_done      - counter has reached zero
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/alu_issue_sequencer.sv
// ============================================================================
//  Module   : alu_issue_sequencer
//  Purpose  : Initiator for TotalALU. Takes one request, drives operands and
//             function code from flops for the op's fixed latency, captures
//             the ALU output and returns it on the response port. DIVU waits
//             out the divider, then reads HI (MFHI) and LO (MFLO) itself.
//  Ports    : clk, reset (async active-low, shared with TotalALU)
//             bus        - request/response handshake (slave modport)
//             alu_dataA  - operand A to TotalALU
//             alu_dataB  - operand B to TotalALU
//             alu_signal - function code to TotalALU
//             alu_output - result from TotalALU
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_sequencer
  import alu_pkg::*;
#(
  parameter int         COMB_LAT  = 2,
  parameter int         DIV_LAT   = 32,
  parameter int         HILO_LAT  = 1,
  parameter logic [5:0] IDLE_FUNC = 6'b000000
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_issue_sequencer_if.slave  bus,
  output logic [31:0]           alu_dataA,
  output logic [31:0]           alu_dataB,
  output logic [5:0]            alu_signal,
  input  logic [31:0]           alu_output
);

  localparam int               CNT_W      = $clog2(DIV_LAT + HILO_LAT + 1);
  localparam logic [CNT_W-1:0] c_LOAD_ALU = CNT_W'(COMB_LAT);
  localparam logic [CNT_W-1:0] c_LOAD_DIV = CNT_W'(DIV_LAT + HILO_LAT);

  seq_state_t  r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic [31:0] r_rsp_hi;
  logic        r_rsp_err;
  logic [31:0] r_dataA;
  logic [31:0] r_dataB;
  logic [5:0]  r_signal;

  logic             w_accept;
  logic             w_supported;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;

  assign w_accept    = bus.req_valid & r_req_ready;
  assign w_supported = is_supported(bus.req_func);

  // Timer is reloaded on the same edge the FSM enters a timed state.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_supported) begin
          w_load     = 1'b1;
          w_load_val = (bus.req_func == c_FUNC_DIVU) ? c_LOAD_DIV : c_LOAD_ALU;
        end
      end
      ST_DIV_WAIT, ST_RD_HI: begin
        if (w_done) begin
          w_load     = 1'b1;
          w_load_val = c_LOAD_ALU;
        end
      end
      default: ;
    endcase
  end

  alu_seq_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_hi    <= '0;
      r_rsp_err   <= 1'b0;
      r_dataA     <= '0;
      r_dataB     <= '0;
      r_signal    <= IDLE_FUNC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_hi    <= '0;
            if (w_supported) begin
              r_dataA   <= bus.req_a;
              r_dataB   <= bus.req_b;
              r_signal  <= bus.req_func;
              r_rsp_err <= 1'b0;
              r_state   <= (bus.req_func == c_FUNC_DIVU) ? ST_DIV_WAIT : ST_EXEC;
            end else begin
              // ALU is left untouched; response raised on the next edge.
              r_rsp_err <= 1'b1;
              r_state   <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          if (w_done) begin
            r_rsp_data  <= alu_output;
            r_signal    <= IDLE_FUNC;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_DIV_WAIT: begin
          if (w_done) begin
            r_signal <= c_FUNC_MFHI;
            r_state  <= ST_RD_HI;
          end
        end
        ST_RD_HI: begin
          if (w_done) begin
            r_rsp_hi <= alu_output;
            r_signal <= c_FUNC_MFLO;
            r_state  <= ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (w_done) begin
            r_rsp_data  <= alu_output;
            r_signal    <= IDLE_FUNC;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_signal    <= IDLE_FUNC;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_hi    = r_rsp_hi;
  assign bus.rsp_err   = r_rsp_err;
  assign alu_dataA     = r_dataA;
  assign alu_dataB     = r_dataB;
  assign alu_signal    = r_signal;

endmodule

`default_nettype wire
